// File: rtl/array_eyeriss_ctrl_if.sv
// Control bus between the Eyeriss array sequencer and the PE array, its
// ifm/weight buffers and the ofm collector.
//   start/cfg_steps : run request and step count, driven by the host
//   busy/done       : run status
//   en_i/clr_i/mac_done/ifm_rd : per-row input-side strobes (skewed)
//   en_w/clr_w/wght_rd         : per-column weight load strobes
//   en_o/clr_o/ofm_vld/ofm_row : per-column output drain strobes
interface array_eyeriss_ctrl_if #(
  parameter int HEIGHT = 12,
  parameter int WIDTH  = 14,
  parameter int SWIDTH = 8
);
  localparam int RW = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;

  logic              start;
  logic [SWIDTH-1:0] cfg_steps;
  logic              busy;
  logic              done;
  logic [HEIGHT-1:0] en_i;
  logic [HEIGHT-1:0] clr_i;
  logic [HEIGHT-1:0] mac_done;
  logic [HEIGHT-1:0] ifm_rd;
  logic [WIDTH-1:0]  en_w;
  logic [WIDTH-1:0]  clr_w;
  logic              wght_rd;
  logic [WIDTH-1:0]  en_o;
  logic [WIDTH-1:0]  clr_o;
  logic              ofm_vld;
  logic [RW-1:0]     ofm_row;

  modport master (
    input  start, cfg_steps,
    output busy, done, en_i, clr_i, mac_done, ifm_rd,
           en_w, clr_w, wght_rd, en_o, clr_o, ofm_vld, ofm_row
  );

  modport slave (
    output start, cfg_steps,
    input  busy, done, en_i, clr_i, mac_done, ifm_rd,
           en_w, clr_w, wght_rd, en_o, clr_o, ofm_vld, ofm_row
  );
endinterface

// File: rtl/array_eyeriss_ctrl.sv
// Sequencer for the HEIGHT x WIDTH binary-serial PE array.
// A run is CLR -> WLOAD -> STREAM -> DRAIN -> DONE. Every strobe is a
// registered decode of the state/counter, so outputs trail the state by one
// cycle. Row strobes are produced once for row 0 and then skewed down the
// rows through a one-register-per-row chain (row h = row 0 delayed h cycles).
// Ports:
//   clk, rst : clock, synchronous active-high reset
//   bus      : control bus (master side), see array_eyeriss_ctrl_if

// One skew stage: registers the row strobes handed down from the row above.
module array_eyeriss_lane (
  input  logic clk,
  input  logic rst,
  input  logic en_in,
  input  logic rd_in,
  input  logic md_in,
  output logic en_q,
  output logic rd_q,
  output logic md_q
);
  always_ff @(posedge clk) begin
    if (rst) begin
      en_q <= 1'b0;
      rd_q <= 1'b0;
      md_q <= 1'b0;
    end else begin
      en_q <= en_in;
      rd_q <= rd_in;
      md_q <= md_in;
    end
  end
endmodule

module array_eyeriss_ctrl #(
  parameter int HEIGHT = 12,
  parameter int WIDTH  = 14,
  parameter int IWIDTH = 8,
  parameter int SWIDTH = 8
) (
  input  logic clk,
  input  logic rst,
  array_eyeriss_ctrl_if.master bus
);
  localparam int RW = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;
  localparam int PW = (IWIDTH > 1) ? $clog2(IWIDTH) : 1;
  // Longest phase is STREAM at S = 2^SWIDTH-1; sized so it never wraps.
  localparam int CW = $clog2(((2**SWIDTH) - 1) * IWIDTH + HEIGHT) + 1;

  typedef enum logic [2:0] {IDLE, CLR, WLOAD, STREAM, DRAIN, DONE} state_t;

  state_t            state, state_nx;
  logic [CW-1:0]     cnt;
  logic [SWIDTH-1:0] steps;
  logic [PW-1:0]     ph;
  logic [CW-1:0]     mac_len;
  logic [CW-1:0]     stream_last;

  assign mac_len     = CW'(steps) * CW'(IWIDTH);
  assign stream_last = mac_len + CW'(HEIGHT - 2);

  // next-state
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (bus.start) state_nx = CLR;
      CLR:     state_nx = WLOAD;
      WLOAD:   if (cnt == CW'(HEIGHT - 1)) state_nx = STREAM;
      STREAM:  if (cnt == stream_last)     state_nx = DRAIN;
      DRAIN:   if (cnt == CW'(HEIGHT - 1)) state_nx = DONE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
      steps <= '0;
      ph    <= '0;
    end else begin
      state <= state_nx;
      // counter is the offset within the current phase
      if (state == IDLE || state_nx != state) cnt <= '0;
      else                                    cnt <= cnt + CW'(1);
      if (state == IDLE && bus.start)
        steps <= (bus.cfg_steps == '0) ? SWIDTH'(1) : bus.cfg_steps;
      // bit-serial phase of row 0, restarts on every STREAM entry
      if (state == STREAM) ph <= (ph == PW'(IWIDTH - 1)) ? '0 : ph + PW'(1);
      else                 ph <= '0;
    end
  end

  // row 0 strobes before the skew chain
  logic s_en, s_rd, s_md;
  assign s_en = (state == STREAM) && (cnt < mac_len);
  assign s_rd = s_en && (ph == '0);
  assign s_md = s_en && (ph == PW'(IWIDTH - 1));

  logic [HEIGHT-1:0] en_q, rd_q, md_q;
  logic [HEIGHT-1:0] en_src, rd_src, md_src;

  generate
    if (HEIGHT > 1) begin : g_chain
      assign en_src = {en_q[HEIGHT-2:0], s_en};
      assign rd_src = {rd_q[HEIGHT-2:0], s_rd};
      assign md_src = {md_q[HEIGHT-2:0], s_md};
    end else begin : g_single
      assign en_src = s_en;
      assign rd_src = s_rd;
      assign md_src = s_md;
    end
    for (genvar h = 0; h < HEIGHT; h++) begin : g_row
      array_eyeriss_lane u_lane (
        .clk   (clk),
        .rst   (rst),
        .en_in (en_src[h]),
        .rd_in (rd_src[h]),
        .md_in (md_src[h]),
        .en_q  (en_q[h]),
        .rd_q  (rd_q[h]),
        .md_q  (md_q[h])
      );
    end
  endgenerate

  assign bus.en_i     = en_q;
  assign bus.ifm_rd   = rd_q;
  assign bus.mac_done = md_q;

  // column / status strobes
  always_ff @(posedge clk) begin
    if (rst) begin
      bus.busy    <= 1'b0;
      bus.done    <= 1'b0;
      bus.clr_i   <= '0;
      bus.clr_w   <= '0;
      bus.clr_o   <= '0;
      bus.en_w    <= '0;
      bus.wght_rd <= 1'b0;
      bus.en_o    <= '0;
      bus.ofm_vld <= 1'b0;
      bus.ofm_row <= '0;
    end else begin
      bus.busy    <= (state != IDLE);
      bus.done    <= (state == DONE);
      bus.clr_i   <= {HEIGHT{state == CLR}};
      bus.clr_w   <= {WIDTH{state == CLR}};
      bus.clr_o   <= {WIDTH{state == CLR}};
      bus.en_w    <= {WIDTH{state == WLOAD}};
      bus.wght_rd <= (state == WLOAD);
      bus.en_o    <= {WIDTH{state == DRAIN}};
      bus.ofm_vld <= (state == DRAIN);
      // rows leave the array bottom-first
      bus.ofm_row <= (state == DRAIN) ? (RW'(HEIGHT - 1) - cnt[RW-1:0]) : '0;
    end
  end
endmodule

// File: tb/tb_array_eyeriss_ctrl.sv
module tb_array_eyeriss_ctrl;
  localparam int H  = 12;
  localparam int W  = 14;
  localparam int IW = 8;
  localparam int SW = 8;
  localparam int RW = $clog2(H);

  typedef struct packed {
    logic          busy;
    logic          done;
    logic [H-1:0]  en_i;
    logic [H-1:0]  clr_i;
    logic [H-1:0]  mac_done;
    logic [H-1:0]  ifm_rd;
    logic [W-1:0]  en_w;
    logic [W-1:0]  clr_w;
    logic          wght_rd;
    logic [W-1:0]  en_o;
    logic [W-1:0]  clr_o;
    logic          ofm_vld;
    logic [RW-1:0] ofm_row;
  } obs_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  array_eyeriss_ctrl_if #(.HEIGHT(H), .WIDTH(W), .SWIDTH(SW)) bus ();

  array_eyeriss_ctrl #(.HEIGHT(H), .WIDTH(W), .IWIDTH(IW), .SWIDTH(SW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  obs_t sb[$];
  int done_q[$];
  int mac_cnt = 0;

  // Expected outputs d cycles after the edge that accepted start, S steps.
  function automatic obs_t model(int d, int s);
    obs_t o;
    int tot, t, e, p;
    o   = '0;
    tot = 3 * H + s * IW + 1;
    if (d >= 1 && d <= tot) o.busy = 1'b1;
    if (d == 1) begin
      o.clr_i = '1; o.clr_w = '1; o.clr_o = '1;
    end
    if (d >= 2 && d <= H + 1) begin
      o.en_w = '1; o.wght_rd = 1'b1;
    end
    t = d - (H + 2);
    if (t >= 0 && t < s * IW + H - 1)
      for (int h = 0; h < H; h++)
        if (t >= h && t < h + s * IW) begin
          p = (t - h) % IW;
          o.en_i[h] = 1'b1;
          if (p == 0)      o.ifm_rd[h]   = 1'b1;
          if (p == IW - 1) o.mac_done[h] = 1'b1;
        end
    e = d - (2 * H + s * IW + 1);
    if (e >= 0 && e < H) begin
      o.en_o = '1; o.ofm_vld = 1'b1; o.ofm_row = RW'(H - 1 - e);
    end
    if (d == tot) o.done = 1'b1;
    return o;
  endfunction

  // reference run tracker: pushes one expected record per edge
  bit m_active = 0;
  int m_origin = 0, m_s = 0, m_tot = 0;
  always @(posedge clk) begin
    obs_t x;
    if (rst) begin
      m_active = 0;
      x = '0;
    end else begin
      if (m_active && (cyc - m_origin) > m_tot) m_active = 0;
      if (!m_active && bus.start) begin
        m_active = 1;
        m_origin = cyc;
        m_s      = (bus.cfg_steps == 0) ? 1 : int'(bus.cfg_steps);
        m_tot    = 3 * H + m_s * IW + 1;
      end
      x = m_active ? model(cyc - m_origin, m_s) : '0;
    end
    sb.push_back(x);
    cyc = cyc + 1;
  end

  // monitor
  always @(posedge clk) begin
    obs_t a, x;
    #1;
    a.busy = bus.busy;         a.done = bus.done;
    a.en_i = bus.en_i;         a.clr_i = bus.clr_i;
    a.mac_done = bus.mac_done; a.ifm_rd = bus.ifm_rd;
    a.en_w = bus.en_w;         a.clr_w = bus.clr_w;
    a.wght_rd = bus.wght_rd;   a.en_o = bus.en_o;
    a.clr_o = bus.clr_o;       a.ofm_vld = bus.ofm_vld;
    a.ofm_row = bus.ofm_row;
    if (a.done === 1'b1) done_q.push_back(cyc - 1);
    mac_cnt = mac_cnt + $countones(a.mac_done);
    if (sb.size() > 0) begin
      x = sb.pop_front();
      checks++;
      if (a !== x) begin
        errors++;
        $display("FAIL cycle_%0d outputs: got %h expected %h", cyc - 1, a, x);
      end
    end
  end

  task automatic check(input string name, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  task automatic to_edge(input int e);
    while (cyc < e) @(negedge clk);
  endtask

  // hold start for exactly the edge numbered cyc (next edge)
  task automatic pulse(input int cfg, output int l);
    bus.start     = 1'b1;
    bus.cfg_steps = SW'(cfg);
    l = cyc;
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  int l1, l2, cfg, gap;

  initial begin
    bus.start = 1'b0;
    bus.cfg_steps = '0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (20) @(negedge clk);

    // nominal
    done_q.delete();
    pulse(2, l1);
    to_edge(l1 + 60);
    check("nominal_done_count", done_q.size(), 1);
    if (done_q.size() > 0) check("nominal_done_cycle", done_q[0] - l1, 53);

    // zero steps behaves as one
    done_q.delete(); mac_cnt = 0;
    pulse(0, l1);
    to_edge(l1 + 50);
    check("zero_done_count", done_q.size(), 1);
    if (done_q.size() > 0) check("zero_done_cycle", done_q[0] - l1, 45);
    check("zero_mac_done_total", mac_cnt, H);

    // start while busy, then back-to-back
    done_q.delete();
    pulse(2, l1);
    to_edge(l1 + 5);  pulse(6, l2);
    to_edge(l1 + 30); pulse(7, l2);
    to_edge(l1 + 54); pulse(3, l2);
    check("b2b_launch_gap", l2 - l1, 54);
    to_edge(l2 + 70);
    check("b2b_done_count", done_q.size(), 2);
    if (done_q.size() == 2) begin
      check("b2b_first_done", done_q[0] - l1, 53);
      check("b2b_second_done", done_q[1] - l2, 61);
    end

    // reset mid-STREAM
    done_q.delete();
    pulse(2, l1);
    to_edge(l1 + 20);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    to_edge(l1 + 60);
    check("rst_abandon_done_count", done_q.size(), 0);
    pulse(3, l2);
    to_edge(l2 + 70);
    check("rst_rerun_done_count", done_q.size(), 1);
    if (done_q.size() > 0) check("rst_rerun_done_cycle", done_q[0] - l2, 61);

    // config change after latch
    done_q.delete();
    pulse(2, l1);
    to_edge(l1 + 3);
    bus.cfg_steps = SW'(5);
    to_edge(l1 + 70);
    if (done_q.size() > 0) check("cfg_hold_done_cycle", done_q[0] - l1, 53);
    else check("cfg_hold_done_count", 0, 1);

    // maximum steps
    done_q.delete();
    pulse(255, l1);
    to_edge(l1 + 3 * H + 255 * IW + 5);
    if (done_q.size() > 0) check("max_done_cycle", done_q[0] - l1, 3 * H + 255 * IW + 1);
    else check("max_done_count", 0, 1);

    // randomized runs with stray starts and occasional resets
    for (int i = 0; i < 10; i++) begin
      cfg = $urandom_range(0, 12);
      pulse(cfg, l1);
      repeat ($urandom_range(1, 4)) begin
        to_edge(l1 + $urandom_range(1, 3 * H + 8));
        if ($urandom_range(0, 5) == 0) begin
          rst = 1'b1; @(negedge clk); rst = 1'b0;
        end else begin
          bus.start = 1'b1;
          bus.cfg_steps = SW'($urandom_range(0, 255));
          @(negedge clk);
          bus.start = 1'b0;
        end
      end
      gap = $urandom_range(0, 3);
      to_edge(l1 + 3 * H + ((cfg == 0) ? 1 : cfg) * IW + 2 + gap);
    end

    repeat (5) @(negedge clk);
    begin
      int n = 0;
      while (sb.size() > 0 && n < 10) begin @(negedge clk); n++; end
      check("scoreboard_drained", sb.size(), 0);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end
endmodule
